d16_imem_loader: RTL and testbench

Instruction-memory responder for the d16 core's instruction bus, with a byte-stream program loader. After reset it holds the core in reset while a host streams program bytes, which are assembled little-endian into 32-bit words and written to on-chip RAM. After the last byte it releases the core and serves `ins_a` fetches with one-cycle synchronous read latency.

---
 rtl/d16_imem_loader_pkg.sv | 25 ++
 rtl/d16_imem_loader_ram.sv | 35 +++
 rtl/d16_imem_loader.sv | 128 ++++++++++++
 tb/tb_d16_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/d16_imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// d16_imem_loader_pkg
// Shared constants for the d16 instruction-memory loader: loader FSM state
// encodings, the default memory depth and a byte-lane insert helper.
// -----------------------------------------------------------------------------
package d16_imem_loader_pkg;

  // Default word-address width: 2^10 words of 32 bits.
  localparam int D16_IMEM_AW = 10;

  // Loader FSM state encodings.
  localparam logic [0:0] D16_IMEM_LOAD = 1'b0;
  localparam logic [0:0] D16_IMEM_RUN  = 1'b1;

  // Returns word with byte lane `lane` (0 = bits 7:0) replaced by `data`.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  data);
    logic [31:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/d16_imem_loader_ram.sv
// -----------------------------------------------------------------------------
// d16_imem_ram
// Simple dual-port RAM, 2^AW words of 32 bits: one synchronous write port and
// one synchronous read port (one-cycle read latency).
// Ports:
//   clk      - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write word address
//   i_wdata  - write data
//   i_raddr  - read word address, sampled on the rising edge
//   o_rdata  - registered read data
// -----------------------------------------------------------------------------
module d16_imem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive
  // both reset and reload, and a read of a never-written word is undefined.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/d16_imem_loader.sv
// -----------------------------------------------------------------------------
// d16_imem_loader
// Instruction-memory responder for the d16 core with a byte-stream loader.
// After reset the core is held while a host streams program bytes; they are
// packed little-endian into 32-bit words and written to RAM. After the byte
// flagged last the core is released and ins_a fetches are served with one
// cycle of read latency.
// Ports:
//   sys_clk   - clock, rising edge
//   sys_rst   - asynchronous active-low reset
//   ins_a     - core fetch byte address (bits 1:0 ignored)
//   ins_di    - fetched word; 0 while loading or when ins_a is out of range
//   ld_valid  - loader byte valid
//   ld_data   - loader byte
//   ld_last   - final byte of the image (with ld_valid)
//   ld_ready  - loader accepts bytes (LOAD)
//   ld_start  - one-cycle reload request, honoured only in RUN
//   cpu_hold  - reset request to the core (LOAD)
//   ld_done   - image loaded, core released (RUN)
//   ld_err    - sticky: partial last word or write past the end of memory
// -----------------------------------------------------------------------------
module d16_imem_loader
  import d16_imem_loader_pkg::*;
#(
  parameter int AW = D16_IMEM_AW
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] ins_a,
  output logic [31:0] ins_di,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        ld_start,
  output logic        cpu_hold,
  output logic        ld_done,
  output logic        ld_err
);

  logic [0:0]  r_state;
  logic [AW:0] r_wr_ptr;    // one extra bit: value 2^AW means memory full
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;       // lanes 0..2; lane 3 never needs storing
  logic        r_err;
  logic        r_rd_zero;   // forces ins_di to 0 for the current read cycle

  logic        w_load;
  logic        w_xfer;
  logic        w_word_end;
  logic        w_full;
  logic        w_we;
  logic        w_oob;
  logic [31:0] w_word;
  logic [31:0] w_rd_q;

  assign w_load     = (r_state == D16_IMEM_LOAD);
  assign w_xfer     = w_load && ld_valid;
  // Upper lanes of r_asm are always zero here, so a partial last word comes
  // out zero-padded without extra masking.
  assign w_word     = put_lane({8'h00, r_asm}, r_byte_cnt, ld_data);
  assign w_word_end = w_xfer && ((r_byte_cnt == 2'd3) || ld_last);
  assign w_full     = r_wr_ptr[AW];
  assign w_we       = w_word_end && !w_full;
  assign w_oob      = ((ins_a >> (AW + 2)) != 16'h0000);

  d16_imem_ram #(.AW(AW)) u_ram (
    .clk     (sys_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_word),
    .i_raddr (ins_a[AW+1:2]),
    .o_rdata (w_rd_q)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state    <= D16_IMEM_LOAD;
      r_wr_ptr   <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_err      <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      // The read issued on an edge that leaves RUN, or that sees LOAD (including
      // the edge writing the final word), must not reach the core.
      r_rd_zero <= w_load || ld_start || w_oob;

      if (w_load) begin
        if (w_xfer) begin
          if (w_word_end) begin
            r_asm      <= '0;
            r_byte_cnt <= '0;
            if (w_full) begin
              r_err <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end else begin
            r_asm      <= w_word[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          if (ld_last) begin
            if (r_byte_cnt != 2'd3) begin
              r_err <= 1'b1;
            end
            r_state <= D16_IMEM_RUN;
          end
        end
      end else if (ld_start) begin
        r_state    <= D16_IMEM_LOAD;
        r_wr_ptr   <= '0;
        r_byte_cnt <= '0;
        r_asm      <= '0;
        r_err      <= 1'b0;
      end
    end
  end

  assign ins_di   = r_rd_zero ? 32'h0000_0000 : w_rd_q;
  assign ld_ready = w_load;
  assign cpu_hold = w_load;
  assign ld_done  = !w_load;
  assign ld_err   = r_err;

endmodule

// File: tb/tb_d16_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_d16_imem_loader
// Self-checking bench for d16_imem_loader with a 4-word memory (AW=2) so that
// overflow and out-of-range fetches are reachable. Expected words come from a
// reference model that packs each whole image little-endian in one step.
// -----------------------------------------------------------------------------
module tb_d16_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [15:0] ins_a   = '0;
  logic [31:0] ins_di;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data  = '0;
  logic        ld_last  = 1'b0;
  logic        ld_ready;
  logic        ld_start = 1'b0;
  logic        cpu_hold;
  logic        ld_done;
  logic        ld_err;

  d16_imem_loader #(.AW(AW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .ins_a    (ins_a),
    .ins_di   (ins_di),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_start (ld_start),
    .cpu_hold (cpu_hold),
    .ld_done  (ld_done),
    .ld_err   (ld_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Whole-image model: word w is bytes 4w..4w+3 little-endian, zero padded;
  // only the first DEPTH words land; error if a word is partial or dropped.
  task automatic model_load(input logic [7:0] img[$]);
    int n;
    int nw;
    logic [31:0] word;
    n  = img.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) word[8*k +: 8] = img[4 * w + k];
      end
      if (w < DEPTH) begin
        m_mem[w]   = word;
        m_known[w] = 1'b1;
      end
    end
    m_err = ((n % 4) != 0) || (nw > DEPTH);
  endtask

  task automatic check_load_outputs();
    check("ld_ready_load", 32'(ld_ready), 32'd1);
    check("cpu_hold_load", 32'(cpu_hold), 32'd1);
    check("ld_done_load",  32'(ld_done),  32'd0);
    check("ins_di_load",   ins_di,        32'h0);
  endtask

  // Streams an image; with gaps, idle cycles (with stray ld_start, which must
  // be ignored in LOAD) are inserted between bytes.
  task automatic send_image(input logic [7:0] img[$], input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge sys_clk);
          check_load_outputs();
          ld_valid = 1'b0;
          ld_last  = 1'b0;
          ld_start = 1'($urandom_range(0, 1));
        end
      end
      @(negedge sys_clk);
      check_load_outputs();
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = (i == img.size() - 1);
      ld_start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge sys_clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_start = 1'b0;
    model_load(img);
    check("cpu_hold_run", 32'(cpu_hold), 32'd0);
    check("ld_done_run",  32'(ld_done),  32'd1);
    check("ld_ready_run", 32'(ld_ready), 32'd0);
    check("ld_err",       32'(ld_err),   32'(m_err));
  endtask

  task automatic fetch(input logic [15:0] a);
    logic [AW-1:0] idx;
    @(negedge sys_clk);
    ins_a = a;
    @(negedge sys_clk);
    idx = a[AW+1:2];
    if ((a >> (AW + 2)) != 16'h0) begin
      check("fetch_oob", ins_di, 32'h0);
    end else if (m_known[idx]) begin
      check($sformatf("fetch_%04h", a), ins_di, m_mem[idx]);
    end
  endtask

  task automatic start_reload();
    @(negedge sys_clk);
    ld_start = 1'b1;
    @(negedge sys_clk);
    ld_start = 1'b0;
    check("reload_ready", 32'(ld_ready), 32'd1);
    check("reload_hold",  32'(cpu_hold), 32'd1);
    check("reload_done",  32'(ld_done),  32'd0);
    check("reload_err",   32'(ld_err),   32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ins_di"},   ins_di,         32'h0);
    check({tag, "_ld_ready"}, 32'(ld_ready),  32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_hold),  32'd1);
    check({tag, "_ld_done"},  32'(ld_done),   32'd0);
    check({tag, "_ld_err"},   32'(ld_err),    32'd0);
  endtask

  initial begin
    logic [7:0] img[$];

    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_err = 1'b0;

    #1;
    check_reset_values("rst");
    @(negedge sys_clk);
    sys_rst = 1'b1;

    // Two full words.
    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h90};
    send_image(img, 1'b0);
    fetch(16'h0004);
    fetch(16'h0007);
    fetch(16'h0000);
    fetch(16'h0010);

    // Partial last word.
    start_reload();
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_image(img, 1'b0);
    fetch(16'h0004);
    fetch(16'h0001);

    // Five full words into a four-word memory.
    start_reload();
    img.delete();
    repeat (20) img.push_back(8'($urandom));
    send_image(img, 1'b0);
    fetch(16'h0010);
    fetch(16'h000C);
    fetch(16'h8000);

    // Reload of one word keeps the others.
    start_reload();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_image(img, 1'b0);
    fetch(16'h0000);
    fetch(16'h0004);

    // Asynchronous reset while in RUN.
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    #1 check_reset_values("rst_run");
    @(negedge sys_clk);
    sys_rst = 1'b1;

    // Asynchronous reset mid-word, then a clean one-word load.
    @(negedge sys_clk);
    ld_valid = 1'b1;
    ld_data  = 8'h11;
    @(negedge sys_clk);
    ld_data  = 8'h22;
    @(negedge sys_clk);
    ld_valid = 1'b0;
    #2 sys_rst = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge sys_clk);
    sys_rst = 1'b1;
    img = '{8'h44, 8'h33, 8'h22, 8'h11};
    send_image(img, 1'b0);
    fetch(16'h0000);
    fetch(16'h0006);

    // Randomized reloads and fetches.
    repeat (30) begin
      start_reload();
      img.delete();
      repeat ($urandom_range(1, 22)) img.push_back(8'($urandom));
      send_image(img, 1'b1);
      repeat (4) begin
        if ($urandom_range(0, 7) == 0) fetch(16'($urandom));
        else fetch(16'($urandom_range(0, 31)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
